// File: rtl/result_gather.sv
// Four-lane result collector: per-lane FIFOs absorb lane skew and short stalls,
// and in-order four-lane tuples leave through one registered valid/ready port.
module result_gather #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid_a,
  input  logic                 i_valid_b,
  input  logic                 i_valid_c,
  input  logic                 i_valid_d,
  input  logic [DATAWIDTH:0]   i_data_a,
  input  logic [DATAWIDTH:0]   i_data_b,
  input  logic [DATAWIDTH:0]   i_data_c,
  input  logic [DATAWIDTH:0]   i_data_d,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATAWIDTH:0]   o_data_a,
  output logic [DATAWIDTH:0]   o_data_b,
  output logic [DATAWIDTH:0]   o_data_c,
  output logic [DATAWIDTH:0]   o_data_d,
  output logic                 o_overflow,
  output logic [15:0]          o_tuple_cnt
);

  localparam int W  = DATAWIDTH + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t         state;
  logic [W-1:0]   mem    [4][DEPTH];
  logic [AW-1:0]  rd_ptr [4];
  logic [AW-1:0]  wr_ptr [4];
  logic [AW:0]    cnt    [4];
  logic [W-1:0]   in_data[4];
  logic [3:0]     in_valid;
  logic [3:0]     push;
  logic [3:0]     full;
  logic           tuple_ready;
  logic           pop;

  assign in_valid = {i_valid_d, i_valid_c, i_valid_b, i_valid_a};
  assign o_valid  = (state == HOLD);

  always_comb begin
    in_data[0] = i_data_a;
    in_data[1] = i_data_b;
    in_data[2] = i_data_c;
    in_data[3] = i_data_d;
    tuple_ready = 1'b1;
    full = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      if (cnt[l] == '0) tuple_ready = 1'b0;
      full[l] = (cnt[l] == (AW+1)'(DEPTH));
    end
    // All four lanes pop together; a same-edge pop frees room for a push into a full FIFO.
    pop  = tuple_ready && ((state == EMPTY) || i_ready);
    push = in_valid & (~full | {4{pop}});
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (push[l]) mem[l][wr_ptr[l]] <= in_data[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < 4; l++) begin
        rd_ptr[l] <= '0;
        wr_ptr[l] <= '0;
        cnt[l]    <= '0;
      end
      o_overflow <= 1'b0;
    end else begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (push[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
        if (pop)     rd_ptr[l] <= rd_ptr[l] + 1'b1;
        cnt[l] <= cnt[l] + (AW+1)'(push[l]) - (AW+1)'(pop);
      end
      if ((in_valid & full & ~{4{pop}}) != '0) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_data_c    <= '0;
      o_data_d    <= '0;
      o_tuple_cnt <= '0;
    end else begin
      if (pop) begin
        o_data_a <= mem[0][rd_ptr[0]];
        o_data_b <= mem[1][rd_ptr[1]];
        o_data_c <= mem[2][rd_ptr[2]];
        o_data_d <= mem[3][rd_ptr[3]];
      end
      case (state)
        EMPTY: if (tuple_ready) state <= HOLD;
        HOLD: begin
          if (i_ready) begin
            o_tuple_cnt <= o_tuple_cnt + 16'd1;
            if (!tuple_ready) state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_result_gather.sv
// Bench for result_gather: directed stimulus pushes expected tuples into a queue,
// an independent monitor pops and compares each tuple accepted downstream.
module tb_result_gather;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int W  = DW + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
  } tup_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid_a = 1'b0, i_valid_b = 1'b0, i_valid_c = 1'b0, i_valid_d = 1'b0;
  logic [W-1:0] i_data_a = '0, i_data_b = '0, i_data_c = '0, i_data_d = '0;
  logic         i_ready = 1'b0;
  logic         o_valid;
  logic [W-1:0] o_data_a, o_data_b, o_data_c, o_data_d;
  logic         o_overflow;
  logic [15:0]  o_tuple_cnt;

  tup_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] mcnt = '0;

  result_gather #(.DATAWIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid_a(i_valid_a), .i_valid_b(i_valid_b), .i_valid_c(i_valid_c), .i_valid_d(i_valid_d),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_data_c(i_data_c), .i_data_d(i_data_d),
    .i_ready(i_ready), .o_valid(o_valid),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_data_c(o_data_c), .o_data_d(o_data_d),
    .o_overflow(o_overflow), .o_tuple_cnt(o_tuple_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tuple accepted downstream must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, o_valid}, 32'd0);
      end else if (i_ready) begin
        tup_t e;
        e = sb.pop_front();
        check("lane_a", {15'd0, o_data_a}, {15'd0, e.a});
        check("lane_b", {15'd0, o_data_b}, {15'd0, e.b});
        check("lane_c", {15'd0, o_data_c}, {15'd0, e.c});
        check("lane_d", {15'd0, o_data_d}, {15'd0, e.d});
        check("tuple_cnt_at_accept", {16'd0, o_tuple_cnt}, {16'd0, mcnt});
        mcnt = mcnt + 16'd1;
      end
    end
  end

  function automatic tup_t mk(input int k);
    tup_t t;
    t.a = W'(k);
    t.b = W'(k + 'h100);
    t.c = W'(k + 'h200);
    t.d = W'(k + 'h300);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input tup_t t);
    i_valid_a = v[0]; i_valid_b = v[1]; i_valid_c = v[2]; i_valid_d = v[3];
    i_data_a = t.a; i_data_b = t.b; i_data_c = t.c; i_data_d = t.d;
  endtask

  task automatic idle();
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_valid_c = 1'b0; i_valid_d = 1'b0;
  endtask

  task automatic send(input tup_t t, input bit expected);
    drive(4'hF, t);
    if (expected) sb.push_back(t);
    tick();
    idle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    mcnt = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tup_t t;
    tick();
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_data_a", {15'd0, o_data_a}, 0);
    check("rst_data_d", {15'd0, o_data_d}, 0);
    check("rst_overflow", {31'd0, o_overflow}, 0);
    check("rst_cnt", {16'd0, o_tuple_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // Aligned tuple: written at edge t, visible after edge t+1.
    i_ready = 1'b1;
    t.a = 17'h00100; t.b = 17'h00200; t.c = 17'h00300; t.d = 17'h00400;
    send(t, 1'b1);
    check("aligned_lat_t", {31'd0, o_valid}, 0);
    tick();
    check("aligned_valid", {31'd0, o_valid}, 1);
    check("aligned_data_c", {15'd0, o_data_c}, 32'h300);
    tick();
    check("aligned_after", {31'd0, o_valid}, 0);
    check("aligned_cnt", {16'd0, o_tuple_cnt}, 1);

    // Skew: one lane per edge, tuple only after the last lane lands.
    t = mk(1);
    t.b = 17'd2; t.c = 17'd3; t.d = 17'd4;
    sb.push_back(t);
    for (int i = 0; i < 4; i++) begin
      drive(4'(1 << i), t);
      tick();
      check("skew_wait", {31'd0, o_valid}, 0);
    end
    idle();
    tick();
    check("skew_valid", {31'd0, o_valid}, 1);
    check("skew_data_d", {15'd0, o_data_d}, 4);
    tick();
    check("skew_cnt", {16'd0, o_tuple_cnt}, 2);

    // Full plus simultaneous push/pop: no overflow, continuous delivery.
    do_reset();
    i_ready = 1'b0;
    for (int k = 11; k <= 15; k++) send(mk(k), 1'b1);
    check("fs_hold", {31'd0, o_valid}, 1);
    check("fs_hold_a", {15'd0, o_data_a}, 11);
    i_ready = 1'b1;
    for (int k = 16; k < 24; k++) begin
      send(mk(k), 1'b1);
      check("fs_cont_valid", {31'd0, o_valid}, 1);
      check("fs_no_ovf", {31'd0, o_overflow}, 0);
    end
    drain(20);
    check("fs_ovf_end", {31'd0, o_overflow}, 0);
    check("fs_cnt", {16'd0, o_tuple_cnt}, 13);

    // Backpressure: DEPTH+1 tuples fit, the next one is dropped.
    do_reset();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(mk(k), 1'b1);
    check("bp_valid", {31'd0, o_valid}, 1);
    check("bp_hold_a", {15'd0, o_data_a}, 1);
    check("bp_no_ovf", {31'd0, o_overflow}, 0);
    send(mk(6), 1'b0);
    check("bp_ovf", {31'd0, o_overflow}, 1);
    check("bp_still_1", {15'd0, o_data_b}, 32'h101);
    i_ready = 1'b1;
    drain(20);
    tick();
    check("bp_cnt", {16'd0, o_tuple_cnt}, 5);
    check("bp_empty", {31'd0, o_valid}, 0);
    check("bp_ovf_sticky", {31'd0, o_overflow}, 1);

    // Reset mid-operation with tuples buffered and overflow set.
    i_ready = 1'b0;
    for (int k = 31; k <= 33; k++) send(mk(k), 1'b1);
    check("rm_pre_valid", {31'd0, o_valid}, 1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    mcnt = '0;
    #2;
    check("rm_valid", {31'd0, o_valid}, 0);
    check("rm_data_a", {15'd0, o_data_a}, 0);
    check("rm_data_b", {15'd0, o_data_b}, 0);
    check("rm_ovf", {31'd0, o_overflow}, 0);
    check("rm_cnt", {16'd0, o_tuple_cnt}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("rm_no_spurious", {31'd0, o_valid}, 0);
    i_ready = 1'b1;
    send(mk(7), 1'b1);
    drain(10);
    tick();
    check("rm_cnt_one", {16'd0, o_tuple_cnt}, 1);
    check("rm_idle", {31'd0, o_valid}, 0);

    // Counter wrap after 65536 accepted tuples.
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 65535; k++) send(mk(k), 1'b1);
    drain(20);
    check("wrap_ffff", {16'd0, o_tuple_cnt}, 32'hFFFF);
    send(mk(65535), 1'b1);
    drain(20);
    check("wrap_zero", {16'd0, o_tuple_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_gather.md
# result_gather

Output-side collector for the four-lane arithmetic pipeline. It receives the four independently-valid result lanes (A, B, C, D), each DATAWIDTH+1 bits wide. It buffers each lane in its own FIFO, reassembles them into in-order four-lane tuples, and presents each tuple on a single registered valid/ready interface for downstream consumers. The upstream pipeline has no backpressure, so this block absorbs lane skew and short downstream stalls, and flags any lost result.

## Interface
- DATAWIDTH, 16, input operand width; lane results are DATAWIDTH+1 bits
- DEPTH, 4, per-lane FIFO depth; power of two, >= 2

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid_a/b/c/d  in  1 each  lane result valid, single-cycle qualifier
- i_data_a/b/c/d  in  DATAWIDTH+1 each  lane result
- i_ready  in  1  downstream accepts the tuple this cycle
- o_valid  out  1  tuple on o_data_* is valid
- o_data_a/b/c/d  out  DATAWIDTH+1 each  registered tuple lanes
- o_overflow  out  1  sticky flag: a lane result was dropped
- o_tuple_cnt  out  16  count of tuples accepted downstream (o_valid & i_ready); wraps

## Operation
- Per lane: circular FIFO of DEPTH entries with read pointer, write pointer and occupancy count (0..DEPTH).
- Push: i_valid_x=1 at an edge writes i_data_x if the FIFO is not full, or if a pop of that FIFO occurs on the same edge.
- Drop: if full and no same-edge pop, the result is discarded, o_overflow is set to 1 and stays set until reset, and the other lanes are unaffected.
- tuple_ready = all four FIFOs non-empty (pre-edge occupancy).
- Output stage FSM, states EMPTY and HOLD:
  - EMPTY: if tuple_ready, pop all four FIFOs, load o_data_*, go to HOLD.
  - HOLD, i_ready=1: accept the tuple and increment o_tuple_cnt. If tuple_ready, reload in the same cycle and stay in HOLD; otherwise go to EMPTY.
  - HOLD, i_ready=0: hold o_data_* stable; no pop.
- o_valid = (state == HOLD). o_data_* changes only on a load.
- Pops are all-four-or-none. Ordering within each lane is strict FIFO, so the n-th result on every lane forms tuple n.
- o_tuple_cnt wraps 16'hFFFF -> 16'h0000.
- Maximum buffered tuples = DEPTH + 1 (FIFOs plus output register).

## Timing
- Reset (rst_n=0, asynchronous): FIFOs empty and pointers 0, state EMPTY, o_valid=0, o_data_*=0, o_overflow=0, o_tuple_cnt=0.
- Reset mid-operation: all buffered and held tuples are discarded immediately; no spurious o_valid after release.
- Latency: if the last missing lane of a tuple is written at edge t and the output stage is free, o_valid=1 after edge t+1. Minimum end-to-end latency is 2 edges.
- Throughput: one tuple per cycle when i_ready=1 continuously and lanes are aligned.
- Push to an empty FIFO at edge t is not visible to tuple_ready until after edge t; there is no combinational bypass.
- Full FIFO with same-edge push and pop: both happen, occupancy stays DEPTH, no overflow.
- i_valid_x during reset assertion is ignored.

## Test plan
- Aligned tuple: at edge t drive A..D = 17'h00100, 17'h00200, 17'h00300, 17'h00400, with i_ready=1 -> o_valid=1 after edge t+1 with those values; o_valid=0 after t+2; o_tuple_cnt=1.
- Skew: A at t, B at t+1, C at t+2, D at t+3 (values 1, 2, 3, 4) -> o_valid stays 0 until after edge t+4, then presents 1, 2, 3, 4.
- Backpressure (DEPTH=4): i_ready=0, drive 5 aligned tuples with values 1..5 -> o_valid=1 holding tuple 1, o_overflow=0. A 6th tuple (value 6) -> o_overflow=1. Raise i_ratio i_ready=1 -> tuples 1..5 delivered in order on consecutive cycles; 6 never appears; o_tuple_cnt=5.
- Full plus simultaneous: fill to DEPTH+1, then push while i_ready=1 every cycle for 8 cycles -> no overflow, every tuple delivered in order, o_valid continuously 1.
- Reset mid-operation: 3 tuples buffered, i_ready=0, pulse rst_n low for half a cycle -> o_valid, o_data_*, o_overflow and o_tuple_cnt are 0 immediately. After release, a new aligned tuple (value 7) is delivered alone.
- Counter wrap: deliver 65536 aligned tuples with i_ready=1 -> o_tuple_cnt reads 16'hFFFF after the 65535th tuple and 16'h0000 after the 65536th.
